// File: rtl/fetch_pkg.sv
// Purpose: shared state encoding and default parameters for the fetch front-end.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Optional feature macro used by this slice: FETCH_BREAKPOINT_EN.
package fetch_pkg;

    localparam int DEF_PC_W     = 12;
    localparam int DEF_PC_INC   = 1;
    localparam int DEF_RESET_PC = 0;

    // ST_HALT is only reachable when FETCH_BREAKPOINT_EN is defined.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_HALT  = 2'd3
    } state_e;

endpackage

// File: rtl/fetch_if.sv
// Purpose: fetch-to-decode handshake bundle (PC, valid, ready).
// Latency: n/a (wires only).
// Backpressure: decode drops i_ready to hold o_pc; master keeps o_pc stable while o_valid && !i_ready.
// Ports: o_pc / o_valid driven by the fetch unit (master), i_ready driven by decode (slave).
interface fetch_if #(
    parameter int PC_W = 12
);
    logic [PC_W-1:0] o_pc;
    logic            o_valid;
    logic            i_ready;

    modport master (output o_pc, output o_valid, input  i_ready);
    modport slave  (input  o_pc, input  o_valid, output i_ready);
endinterface

// File: rtl/fetch_bp_match.sv
// Purpose: breakpoint comparator with a one-shot suppression armed by resume.
// Latency: combinational hit; suppression flag registered, cleared by the next PC load.
// Backpressure: none; the caller gates i_load / i_resume with stop and handshake.
// Ports: i_cand_pc is the PC about to be loaded into o_pc; o_hit flags a match on that load.
module fetch_bp_match #(
    parameter int PC_W = 12
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_bp_en,
    input  logic [PC_W-1:0] i_bp_addr,
    input  logic [PC_W-1:0] i_cand_pc,
    input  logic            i_load,
    input  logic            i_resume,
    output logic            o_hit
);

    logic suppress_q, suppress_d;

    // After a resume the first load must not re-trigger on the same address,
    // otherwise PC_INC=0 or a wrap back onto the breakpoint would trap forever.
    always_comb begin
        suppress_d = suppress_q;
        if (i_resume) begin
            suppress_d = 1'b1;
        end else if (i_load) begin
            suppress_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            suppress_q <= 1'b0;
        end else begin
            suppress_q <= suppress_d;
        end
    end

    assign o_hit = i_bp_en && (i_cand_pc == i_bp_addr) && !suppress_q;

endmodule

// File: rtl/fetch_unit.sv
// Purpose: parametrised PC generator / one-stage fetch pipeline feeding decode.
// Latency: first valid PC one cycle after reset release; redirect-to-valid-target two cycles.
// Backpressure: o_pc, r_pc and o_valid hold while o_valid && !i_ready; i_stop freezes everything.
// Ports: i_clk, i_reset (async active-low), i_stop, i_redirect, i_target, dec (fetch_if.master:
//        o_pc, o_valid, i_ready), o_state (debug). With FETCH_BREAKPOINT_EN defined also
//        i_bp_en, i_bp_addr, i_resume, o_halted.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int PC_W     = DEF_PC_W,
    parameter int PC_INC   = DEF_PC_INC,
    parameter int RESET_PC = DEF_RESET_PC
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_stop,
    input  logic            i_redirect,
    input  logic [PC_W-1:0] i_target,
`ifdef FETCH_BREAKPOINT_EN
    input  logic            i_bp_en,
    input  logic [PC_W-1:0] i_bp_addr,
    input  logic            i_resume,
    output logic            o_halted,
`endif
    fetch_if.master         dec,
    output logic [1:0]      o_state
);

    localparam logic [PC_W-1:0] RST_V = PC_W'(RESET_PC);
    localparam logic [PC_W-1:0] INC_V = PC_W'(PC_INC);

    state_e          state_q, state_d;
    logic [PC_W-1:0] r_pc_q, r_pc_d;
    logic [PC_W-1:0] o_pc_q, o_pc_d;
    logic            o_valid_q, o_valid_d;
    // Set when the PC now in o_pc matched the breakpoint; halt happens on its acceptance.
    logic            bp_pend_q, bp_pend_d;

    logic load;
    logic halt_go;
    logic resume_go;
    logic bp_hit;
    logic resume_in;

`ifdef FETCH_BREAKPOINT_EN
    assign resume_in = i_resume;

    fetch_bp_match #(.PC_W(PC_W)) u_bp_match (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_bp_en   (i_bp_en),
        .i_bp_addr (i_bp_addr),
        .i_cand_pc (r_pc_q),
        .i_load    (load),
        .i_resume  (resume_go),
        .o_hit     (bp_hit)
    );

    assign o_halted = (state_q == ST_HALT);
`else
    assign resume_in = 1'b0;
    assign bp_hit    = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        r_pc_d    = r_pc_q;
        o_pc_d    = o_pc_q;
        o_valid_d = o_valid_q;
        bp_pend_d = bp_pend_q;
        load      = 1'b0;
        halt_go   = 1'b0;
        resume_go = 1'b0;

        if (!i_stop) begin
            if (i_redirect) begin
                // In-flight PC is dropped regardless of i_ready.
                o_valid_d = 1'b0;
                r_pc_d    = i_target;
                bp_pend_d = 1'b0;
                state_d   = ST_FLUSH;
            end else begin
                unique case (state_q)
                    ST_IDLE, ST_FLUSH: load = 1'b1;
                    ST_RUN: begin
                        if (!o_valid_q || dec.i_ready) begin
                            if (o_valid_q && bp_pend_q) begin
                                halt_go = 1'b1;
                            end else begin
                                load = 1'b1;
                            end
                        end
                    end
                    ST_HALT: resume_go = resume_in;
                    default: ;
                endcase

                if (load) begin
                    o_pc_d    = r_pc_q;
                    r_pc_d    = r_pc_q + INC_V;
                    o_valid_d = 1'b1;
                    bp_pend_d = bp_hit;
                    state_d   = ST_RUN;
                end
                if (halt_go) begin
                    o_valid_d = 1'b0;
                    bp_pend_d = 1'b0;
                    state_d   = ST_HALT;
                end
                if (resume_go) begin
                    state_d = ST_RUN;
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q   <= ST_IDLE;
            r_pc_q    <= RST_V;
            o_pc_q    <= RST_V;
            o_valid_q <= 1'b0;
            bp_pend_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            r_pc_q    <= r_pc_d;
            o_pc_q    <= o_pc_d;
            o_valid_q <= o_valid_d;
            bp_pend_q <= bp_pend_d;
        end
    end

    assign dec.o_pc    = o_pc_q;
    assign dec.o_valid = o_valid_q;
    assign o_state     = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Purpose: self-checking bench for fetch_unit (12-bit main instance plus a 4-bit wrap instance).
// Latency: expects first valid PC one edge after reset release, redirect target two edges later.
// Backpressure: scoreboard pops an expected PC on every accepted fetch (valid && ready, no stop/redirect).
module tb_fetch_unit;

    logic        i_clk;
    logic        i_reset;
    logic        i_stop;
    logic        i_redirect;
    logic [11:0] i_target;
    logic [1:0]  o_state;

    logic        w_reset;
    logic [1:0]  w_state;

    int n_checks;
    int n_fails;
    logic [11:0] exp_q[$];

    fetch_if #(.PC_W(12)) dec_if ();
    fetch_if #(.PC_W(4))  w_if ();

`ifdef FETCH_BREAKPOINT_EN
    logic        i_bp_en;
    logic [11:0] i_bp_addr;
    logic        i_resume;
    logic        o_halted;
    logic        w_halted;
`endif

    fetch_unit #(.PC_W(12), .PC_INC(1), .RESET_PC(0)) dut (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_stop     (i_stop),
        .i_redirect (i_redirect),
        .i_target   (i_target),
`ifdef FETCH_BREAKPOINT_EN
        .i_bp_en    (i_bp_en),
        .i_bp_addr  (i_bp_addr),
        .i_resume   (i_resume),
        .o_halted   (o_halted),
`endif
        .dec        (dec_if),
        .o_state    (o_state)
    );

    fetch_unit #(.PC_W(4), .PC_INC(2), .RESET_PC(12)) u_wrap (
        .i_clk      (i_clk),
        .i_reset    (w_reset),
        .i_stop     (1'b0),
        .i_redirect (1'b0),
        .i_target   (4'h0),
`ifdef FETCH_BREAKPOINT_EN
        .i_bp_en    (1'b0),
        .i_bp_addr  (4'h0),
        .i_resume   (1'b0),
        .o_halted   (w_halted),
`endif
        .dec        (w_if),
        .o_state    (w_state)
    );

    assign w_if.i_ready = 1'b1;

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    // Scoreboard: on the falling edge, a transfer is pending if the next rising
    // edge will consume o_pc (stop and redirect both prevent consumption).
    always @(negedge i_clk) begin
        if (i_reset && dec_if.o_valid && dec_if.i_ready && !i_stop && !i_redirect) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fails++;
                $display("FAIL scoreboard_unexpected: accepted pc=%h, no pc expected", dec_if.o_pc);
            end else begin
                logic [11:0] e;
                e = exp_q.pop_front();
                if (dec_if.o_pc !== e) begin
                    n_fails++;
                    $display("FAIL scoreboard_pc: got %h expected %h", dec_if.o_pc, e);
                end
            end
        end
    end

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_reset();
        i_reset = 1'b0; i_stop = 1'b0; i_redirect = 1'b0; i_target = '0;
        dec_if.i_ready = 1'b0;
        step(); step();
        n_checks++;
        if (dec_if.o_valid !== 1'b0) begin n_fails++; $display("FAIL reset_valid: got %b expected 0", dec_if.o_valid); end
        n_checks++;
        if (dec_if.o_pc !== 12'h000) begin n_fails++; $display("FAIL reset_pc: got %h expected 000", dec_if.o_pc); end
        n_checks++;
        if (o_state !== 2'd0) begin n_fails++; $display("FAIL reset_state: got %0d expected 0", o_state); end
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 5; i++) exp_q.push_back(12'(i));
        dec_if.i_ready = 1'b1;
        i_reset = 1'b1;
        step();
        n_checks++;
        if (dec_if.o_valid !== 1'b1 || dec_if.o_pc !== 12'h000) begin
            n_fails++; $display("FAIL first_fetch: got valid=%b pc=%h expected valid=1 pc=000", dec_if.o_valid, dec_if.o_pc);
        end
        repeat (5) step();
        dec_if.i_ready = 1'b0;
        n_checks++;
        if (dec_if.o_pc !== 12'h005 || o_state !== 2'd1) begin
            n_fails++; $display("FAIL seq_pc5: got pc=%h state=%0d expected pc=005 state=1", dec_if.o_pc, o_state);
        end
        n_checks++;
        if (exp_q.size() != 0) begin n_fails++; $display("FAIL seq_drain: got %0d left expected 0", exp_q.size()); end
    endtask

    task automatic test_hold();
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (dec_if.o_pc !== 12'h005 || dec_if.o_valid !== 1'b1) begin
                n_fails++; $display("FAIL hold_%0d: got pc=%h valid=%b expected pc=005 valid=1", i, dec_if.o_pc, dec_if.o_valid);
            end
        end
        for (int i = 5; i < 16; i++) exp_q.push_back(12'(i));
        dec_if.i_ready = 1'b1;
        step();
        n_checks++;
        if (dec_if.o_pc !== 12'h006) begin n_fails++; $display("FAIL hold_release: got %h expected 006", dec_if.o_pc); end
        repeat (10) step();
        n_checks++;
        if (dec_if.o_pc !== 12'h010) begin n_fails++; $display("FAIL run_to_010: got %h expected 010", dec_if.o_pc); end
    endtask

    task automatic test_redirect();
        exp_q.push_back(12'h3A0);
        i_redirect = 1'b1; i_target = 12'h3A0;
        step();
        i_redirect = 1'b0;
        n_checks++;
        if (dec_if.o_valid !== 1'b0 || o_state !== 2'd2) begin
            n_fails++; $display("FAIL redir_bubble: got valid=%b state=%0d expected valid=0 state=2", dec_if.o_valid, o_state);
        end
        step();
        n_checks++;
        if (dec_if.o_pc !== 12'h3A0 || dec_if.o_valid !== 1'b1) begin
            n_fails++; $display("FAIL redir_target: got pc=%h valid=%b expected pc=3A0 valid=1", dec_if.o_pc, dec_if.o_valid);
        end
        step();
        dec_if.i_ready = 1'b0;
        n_checks++;
        if (dec_if.o_pc !== 12'h3A1) begin n_fails++; $display("FAIL redir_next: got %h expected 3A1", dec_if.o_pc); end
        n_checks++;
        if (exp_q.size() != 0) begin n_fails++; $display("FAIL redir_drain: got %0d left expected 0", exp_q.size()); end
    endtask

    task automatic test_stop();
        i_stop = 1'b1; i_redirect = 1'b1; i_target = 12'h200; dec_if.i_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (dec_if.o_pc !== 12'h3A1 || dec_if.o_valid !== 1'b1 || o_state !== 2'd1) begin
                n_fails++; $display("FAIL stop_frozen_%0d: got pc=%h valid=%b state=%0d expected pc=3A1 valid=1 state=1",
                                    i, dec_if.o_pc, dec_if.o_valid, o_state);
            end
        end
        exp_q.push_back(12'h3A1);
        i_stop = 1'b0; i_redirect = 1'b0;
        step();
        dec_if.i_ready = 1'b0;
        n_checks++;
        if (dec_if.o_pc !== 12'h3A2 || dec_if.o_valid !== 1'b1) begin
            n_fails++; $display("FAIL stop_resume: got pc=%h valid=%b expected pc=3A2 valid=1", dec_if.o_pc, dec_if.o_valid);
        end
        n_checks++;
        if (exp_q.size() != 0) begin n_fails++; $display("FAIL stop_drain: got %0d left expected 0", exp_q.size()); end
    endtask

    task automatic test_back_to_back();
        i_redirect = 1'b1; i_target = 12'h050;
        step();
        i_target = 12'h07B;
        step();
        i_redirect = 1'b0;
        n_checks++;
        if (dec_if.o_valid !== 1'b0 || o_state !== 2'd2) begin
            n_fails++; $display("FAIL b2b_flush: got valid=%b state=%0d expected valid=0 state=2", dec_if.o_valid, o_state);
        end
        step();
        n_checks++;
        if (dec_if.o_pc !== 12'h07B || dec_if.o_valid !== 1'b1) begin
            n_fails++; $display("FAIL b2b_last_wins: got pc=%h valid=%b expected pc=07B valid=1", dec_if.o_pc, dec_if.o_valid);
        end
    endtask

    task automatic test_async_reset();
        i_redirect = 1'b1; i_target = 12'h123;
        step();
        i_redirect = 1'b0;
        n_checks++;
        if (o_state !== 2'd2) begin n_fails++; $display("FAIL areset_pre: got state=%0d expected 2", o_state); end
        #2;
        i_reset = 1'b0;
        #1;
        n_checks++;
        if (dec_if.o_pc !== 12'h000 || dec_if.o_valid !== 1'b0 || o_state !== 2'd0) begin
            n_fails++; $display("FAIL areset_immediate: got pc=%h valid=%b state=%0d expected pc=000 valid=0 state=0",
                                dec_if.o_pc, dec_if.o_valid, o_state);
        end
        step(); step();
        i_reset = 1'b1;
        step();
        n_checks++;
        if (dec_if.o_pc !== 12'h000 || dec_if.o_valid !== 1'b1 || o_state !== 2'd1) begin
            n_fails++; $display("FAIL areset_restart: got pc=%h valid=%b state=%0d expected pc=000 valid=1 state=1",
                                dec_if.o_pc, dec_if.o_valid, o_state);
        end
    endtask

    task automatic test_wrap();
        logic [3:0] exp_seq [4];
        exp_seq[0] = 4'hC; exp_seq[1] = 4'hE; exp_seq[2] = 4'h0; exp_seq[3] = 4'h2;
        w_reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            n_checks++;
            if (w_if.o_pc !== exp_seq[i] || w_if.o_valid !== 1'b1) begin
                n_fails++; $display("FAIL wrap_%0d: got pc=%h valid=%b expected pc=%h valid=1", i, w_if.o_pc, w_if.o_valid, exp_seq[i]);
            end
        end
    endtask

`ifdef FETCH_BREAKPOINT_EN
    task automatic test_breakpoint();
        i_reset = 1'b0;
        step();
        i_bp_en = 1'b1; i_bp_addr = 12'h004;
        for (int i = 0; i < 5; i++) exp_q.push_back(12'(i));
        dec_if.i_ready = 1'b1;
        i_reset = 1'b1;
        repeat (5) step();
        n_checks++;
        if (dec_if.o_pc !== 12'h004 || dec_if.o_valid !== 1'b1) begin
            n_fails++; $display("FAIL bp_presented: got pc=%h valid=%b expected pc=004 valid=1", dec_if.o_pc, dec_if.o_valid);
        end
        step();
        n_checks++;
        if (o_halted !== 1'b1 || dec_if.o_valid !== 1'b0 || o_state !== 2'd3) begin
            n_fails++; $display("FAIL bp_halt: got halted=%b valid=%b state=%0d expected 1 0 3", o_halted, dec_if.o_valid, o_state);
        end
        i_resume = 1'b1;
        step();
        i_resume = 1'b0;
        step();
        dec_if.i_ready = 1'b0;
        n_checks++;
        if (dec_if.o_pc !== 12'h005 || dec_if.o_valid !== 1'b1 || o_halted !== 1'b0) begin
            n_fails++; $display("FAIL bp_resume: got pc=%h valid=%b halted=%b expected 005 1 0", dec_if.o_pc, dec_if.o_valid, o_halted);
        end
        n_checks++;
        if (exp_q.size() != 0) begin n_fails++; $display("FAIL bp_drain: got %0d left expected 0", exp_q.size()); end
    endtask
`endif

    initial begin
        n_checks = 0;
        n_fails  = 0;
        w_reset  = 1'b0;
`ifdef FETCH_BREAKPOINT_EN
        i_bp_en = 1'b0; i_bp_addr = '0; i_resume = 1'b0;
`endif
        test_reset();
        test_sequential();
        test_hold();
        test_redirect();
        test_stop();
        test_back_to_back();
        test_async_reset();
        test_wrap();
`ifdef FETCH_BREAKPOINT_EN
        test_breakpoint();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
